dm_bridge: RTL and testbench

DM_BRIDGE -- requirements
Module: dm_bridge

---
 rtl/dm_bridge_pkg.sv | 17 +
 rtl/dm_bridge_timer.sv | 31 +++
 rtl/dm_bridge.sv | 115 +++++++++++
 tb/tb_dm_bridge.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_bridge_pkg.sv
// Shared definitions for the data-memory bridge: FSM encoding, timeout
// defaults and the read data returned when the memory never answers.
package dm_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_TIMEOUT = 15;

  localparam int WAIT_W = 8;

  localparam logic [31:0] TIMEOUT_RDATA = 32'h0000_0000;

endpackage

// File: rtl/dm_bridge_timer.sv
// Wait-cycle counter for the REQ state. It flags expiry during the last REQ
// cycle the memory is allowed, so the bridge can give up on that same edge.
module dm_bridge_timer #(
  parameter int TIMEOUT = dm_bridge_pkg::DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  import dm_bridge_pkg::*;

  localparam logic [WAIT_W-1:0] LAST = WAIT_W'(TIMEOUT - 1);

  logic [WAIT_W-1:0] count;

  // Count un-acknowledged REQ cycles; cleared when a new access is accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + WAIT_W'(1);
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/dm_bridge.sv
// Bridge between the core's data-memory strobes and a single-request memory
// port with a one-cycle ack. Accesses are latched, issued, and completed via
// IDLE -> REQ -> DONE; a missing ack or a read/write conflict raises a sticky
// bus_error.
module dm_bridge #(
  parameter int TIMEOUT = dm_bridge_pkg::DEFAULT_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        DM_enable,
  input  logic        DM_read,
  input  logic        DM_write,
  input  logic [11:0] DM_address,
  input  logic [31:0] DM_in,
  output logic [31:0] DM_out,
  output logic        DM_stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [11:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        bus_error
);
  import dm_bridge_pkg::*;

  state_t state;
  state_t state_next;

  logic valid_access;
  logic conflict;
  logic accept;
  logic ack_hit;
  logic timeout_hit;
  logic wait_tick;
  logic expired;

  assign valid_access = DM_enable & (DM_read ^ DM_write);
  assign accept       = (state == IDLE) & valid_access;
  assign conflict     = (state == IDLE) & DM_enable & DM_read & DM_write;
  assign ack_hit      = (state == REQ) & mem_ack;
  assign wait_tick    = (state == REQ) & ~mem_ack;
  assign timeout_hit  = wait_tick & expired;

  assign mem_req  = (state == REQ);
  assign DM_stall = (state == REQ) | accept;

  dm_bridge_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (accept),
    .enable  (wait_tick),
    .expired (expired)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; an ack in the last allowed cycle beats the timeout.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = REQ;
        end
      end
      REQ: begin
        if (ack_hit || timeout_hit) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Request latches, read-data register and sticky error flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      DM_out    <= '0;
      bus_error <= 1'b0;
    end else begin
      if (accept) begin
        mem_we    <= DM_write;
        mem_addr  <= DM_address;
        mem_wdata <= DM_in;
      end
      if (ack_hit && !mem_we) begin
        DM_out <= mem_rdata;
      end else if (timeout_hit && !mem_we) begin
        DM_out <= TIMEOUT_RDATA;
      end
      if (conflict || timeout_hit) begin
        bus_error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dm_bridge.sv
// Self-checking bench for dm_bridge: directed scenarios plus randomized
// transactions compared against a transaction-level reference model.
module tb_dm_bridge;

  localparam int TB_TIMEOUT = 15;

  logic        clk;
  logic        rst;
  logic        DM_enable;
  logic        DM_read;
  logic        DM_write;
  logic [11:0] DM_address;
  logic [31:0] DM_in;
  logic [31:0] DM_out;
  logic        DM_stall;
  logic        mem_req;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        bus_error;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] model_out;
  logic        model_err;

  int          obs_cycles;
  logic        obs_stall_acc;
  logic        obs_stall_done;
  logic [11:0] obs_addr;
  logic        obs_we;
  logic [31:0] obs_wdata;
  logic [31:0] obs_out;
  bit          obs_stable;

  dm_bridge #(
    .TIMEOUT(TB_TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .DM_enable  (DM_enable),
    .DM_read    (DM_read),
    .DM_write   (DM_write),
    .DM_address (DM_address),
    .DM_in      (DM_in),
    .DM_out     (DM_out),
    .DM_stall   (DM_stall),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .bus_error  (bus_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference model: a transaction either completes on its ack or times out.
  function automatic int model_access(input bit wr, input int ack_at, input logic [31:0] rd);
    bit acked;
    acked = (ack_at >= 0) && (ack_at < TB_TIMEOUT);
    if (!wr) model_out = acked ? rd : 32'h0000_0000;
    if (!acked) model_err = 1'b1;
    return acked ? ack_at + 1 : TB_TIMEOUT;
  endfunction

  // Run one core access and a memory that acks in REQ cycle ack_at (-1 = never).
  task automatic do_access(input bit wr, input logic [11:0] addr, input logic [31:0] wd,
                           input int ack_at, input logic [31:0] rd);
    @(negedge clk);
    DM_enable  = 1'b1;
    DM_read    = ~wr;
    DM_write   = wr;
    DM_address = addr;
    DM_in      = wd;
    #1 obs_stall_acc = DM_stall;
    obs_cycles = 0;
    obs_stable = 1'b1;
    @(negedge clk);
    obs_addr  = mem_addr;
    obs_we    = mem_we;
    obs_wdata = mem_wdata;
    for (int k = 0; k < TB_TIMEOUT + 10 && mem_req === 1'b1; k++) begin
      if (mem_addr !== obs_addr || mem_we !== obs_we || mem_wdata !== obs_wdata) obs_stable = 1'b0;
      obs_cycles++;
      if (k == ack_at) begin
        mem_ack   = 1'b1;
        mem_rdata = rd;
      end
      @(negedge clk);
      mem_ack = 1'b0;
    end
    obs_stall_done = DM_stall;
    obs_out        = DM_out;
    DM_enable = 1'b0;
    DM_read   = 1'b0;
    DM_write  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    DM_enable = 1'b0; DM_read = 1'b0; DM_write = 1'b0;
    DM_address = '0; DM_in = '0; mem_rdata = '0; mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, DM_out, bus_error} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got req=%b we=%b addr=%h wdata=%h out=%h err=%b want all 0",
               mem_req, mem_we, mem_addr, mem_wdata, DM_out, bus_error);
    end
    @(negedge clk);
    rst = 1'b1;
    model_out = 32'h0;
    model_err = 1'b0;
    @(negedge clk);
    vectors++;
    if ({DM_stall, mem_req} !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL reset_idle: got stall=%b req=%b want 0 0", DM_stall, mem_req);
    end
  endtask

  task automatic test_read_fast();
    int exp_c;
    exp_c = model_access(1'b0, 0, 32'hCAFE_F00D);
    do_access(1'b0, 12'h123, $urandom, 0, 32'hCAFE_F00D);
    vectors++;
    if (obs_cycles !== exp_c) begin
      miscompares++;
      $display("[TB] FAIL read_fast_cycles: got %0d want %0d", obs_cycles, exp_c);
    end
    vectors++;
    if ({obs_stall_acc, obs_stall_done} !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL read_fast_stall: got accept=%b done=%b want 1 0", obs_stall_acc, obs_stall_done);
    end
    vectors++;
    if (obs_addr !== 12'h123 || obs_we !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL read_fast_req: got addr=%h we=%b want 123 0", obs_addr, obs_we);
    end
    vectors++;
    if (obs_out !== 32'hCAFE_F00D) begin
      miscompares++;
      $display("[TB] FAIL read_fast_data: got %h want cafef00d", obs_out);
    end
  endtask

  task automatic test_write_wait();
    int exp_c;
    exp_c = model_access(1'b1, 4, 32'h0);
    do_access(1'b1, 12'h0FF, 32'h1234_5678, 4, $urandom);
    vectors++;
    if (obs_cycles !== exp_c) begin
      miscompares++;
      $display("[TB] FAIL write_wait_cycles: got %0d want %0d", obs_cycles, exp_c);
    end
    vectors++;
    if (obs_we !== 1'b1 || obs_addr !== 12'h0FF || obs_wdata !== 32'h1234_5678 || obs_stable !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL write_wait_req: got we=%b addr=%h wdata=%h stable=%b want 1 0ff 12345678 1",
               obs_we, obs_addr, obs_wdata, obs_stable);
    end
    vectors++;
    if (obs_out !== model_out) begin
      miscompares++;
      $display("[TB] FAIL write_wait_dmout: got %h want %h", obs_out, model_out);
    end
  endtask

  task automatic test_conflict();
    logic saw_req;
    saw_req = 1'b0;
    @(negedge clk);
    DM_enable = 1'b1; DM_read = 1'b1; DM_write = 1'b1; DM_address = 12'hABC;
    #1;
    vectors++;
    if (DM_stall !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL conflict_stall: got %b want 0", DM_stall);
    end
    repeat (3) begin
      @(negedge clk);
      saw_req = saw_req | mem_req;
    end
    model_err = 1'b1;
    vectors++;
    if (saw_req !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL conflict_req: got %b want 0", saw_req);
    end
    vectors++;
    if (bus_error !== model_err) begin
      miscompares++;
      $display("[TB] FAIL conflict_error: got %b want %b", bus_error, model_err);
    end
    DM_enable = 1'b0; DM_read = 1'b0; DM_write = 1'b0;
  endtask

  task automatic test_timeout();
    int exp_c;
    logic [31:0] rd;
    exp_c = model_access(1'b0, -1, 32'h0);
    do_access(1'b0, 12'($urandom), $urandom, -1, $urandom);
    vectors++;
    if (obs_cycles !== exp_c) begin
      miscompares++;
      $display("[TB] FAIL timeout_cycles: got %0d want %0d", obs_cycles, exp_c);
    end
    vectors++;
    if (obs_out !== 32'h0000_0000 || bus_error !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL timeout_result: got out=%h err=%b want 00000000 1", obs_out, bus_error);
    end
    rd = $urandom;
    exp_c = model_access(1'b0, 2, rd);
    do_access(1'b0, 12'h456, $urandom, 2, rd);
    @(negedge clk);
    vectors++;
    if (DM_out !== model_out || bus_error !== model_err) begin
      miscompares++;
      $display("[TB] FAIL timeout_sticky: got out=%h err=%b want %h %b", DM_out, bus_error, model_out, model_err);
    end
  endtask

  task automatic test_reset_mid();
    int exp_c;
    logic [31:0] rd;
    @(negedge clk);
    DM_enable = 1'b1; DM_read = 1'b1; DM_write = 1'b0;
    DM_address = 12'h777; DM_in = $urandom;
    repeat (3) @(negedge clk);
    vectors++;
    if (mem_req !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL reset_mid_inreq: got req=%b want 1", mem_req);
    end
    rst = 1'b0;
    DM_enable = 1'b0; DM_read = 1'b0;
    #1;
    vectors++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, DM_out, bus_error, DM_stall} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_mid_outputs: got req=%b we=%b addr=%h wdata=%h out=%h err=%b stall=%b want all 0",
               mem_req, mem_we, mem_addr, mem_wdata, DM_out, bus_error, DM_stall);
    end
    model_out = 32'h0;
    model_err = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    rd = $urandom;
    exp_c = model_access(1'b0, 0, rd);
    do_access(1'b0, 12'h001, $urandom, 0, rd);
    vectors++;
    if (obs_cycles !== exp_c || obs_addr !== 12'h001 || obs_out !== rd || bus_error !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_mid_after: got cycles=%0d addr=%h out=%h err=%b want %0d 001 %h 0",
               obs_cycles, obs_addr, obs_out, bus_error, exp_c, rd);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd_hist [13];
    logic [31:0] held;
    logic stray_bad;
    stray_bad = 1'b0;
    held = model_out;
    @(negedge clk);
    mem_ack = 1'b1;
    repeat (3) begin
      mem_rdata = $urandom;
      @(negedge clk);
      if (DM_out !== held || mem_req !== 1'b0) stray_bad = 1'b1;
    end
    vectors++;
    if (stray_bad !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL stray_ack_idle: got out=%h req=%b want %h 0", DM_out, mem_req, held);
    end
    DM_enable = 1'b1; DM_read = 1'b1; DM_write = 1'b0;
    DM_address = 12'($urandom); DM_in = $urandom;
    for (int i = 0; i < 12; i++) begin
      rd_hist[i] = $urandom;
      mem_rdata = rd_hist[i];
      #1;
      vectors++;
      if (mem_req !== ((i % 3) == 1) || DM_stall !== ((i % 3) != 2)) begin
        miscompares++;
        $display("[TB] FAIL b2b_cycle%0d: got req=%b stall=%b want %b %b",
                 i, mem_req, DM_stall, (i % 3) == 1, (i % 3) != 2);
      end
      if ((i % 3) == 2) begin
        vectors++;
        if (DM_out !== rd_hist[i-1]) begin
          miscompares++;
          $display("[TB] FAIL b2b_data%0d: got %h want %h", i, DM_out, rd_hist[i-1]);
        end
      end
      if ((i % 3) == 0 && i > 0) begin
        vectors++;
        if (DM_out !== rd_hist[i-2]) begin
          miscompares++;
          $display("[TB] FAIL b2b_hold%0d: got %h want %h", i, DM_out, rd_hist[i-2]);
        end
      end
      @(negedge clk);
    end
    DM_enable = 1'b0; DM_read = 1'b0;
    mem_ack = 1'b0;
    model_out = rd_hist[10];
  endtask

  task automatic test_random();
    int exp_c;
    int ack_at;
    int sel;
    bit wr;
    logic [11:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    for (int n = 0; n < 40; n++) begin
      wr   = 1'($urandom_range(0, 1));
      addr = 12'($urandom);
      wd   = $urandom;
      rd   = $urandom;
      sel  = $urandom_range(0, 9);
      ack_at = (sel == 0) ? -1 : (sel == 1) ? TB_TIMEOUT - 1 : $urandom_range(0, 4);
      exp_c = model_access(wr, ack_at, rd);
      do_access(wr, addr, wd, ack_at, rd);
      vectors++;
      if (obs_cycles !== exp_c || obs_stable !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL rand%0d_cycles: got %0d stable=%b want %0d 1", n, obs_cycles, obs_stable, exp_c);
      end
      vectors++;
      if (obs_addr !== addr || obs_we !== wr || obs_wdata !== wd) begin
        miscompares++;
        $display("[TB] FAIL rand%0d_req: got addr=%h we=%b wdata=%h want %h %b %h",
                 n, obs_addr, obs_we, obs_wdata, addr, wr, wd);
      end
      vectors++;
      if ({obs_stall_acc, obs_stall_done} !== 2'b10) begin
        miscompares++;
        $display("[TB] FAIL rand%0d_stall: got accept=%b done=%b want 1 0", n, obs_stall_acc, obs_stall_done);
      end
      vectors++;
      if (obs_out !== model_out || bus_error !== model_err) begin
        miscompares++;
        $display("[TB] FAIL rand%0d_result: got out=%h err=%b want %h %b", n, obs_out, bus_error, model_out, model_err);
      end
    end
  endtask

  initial begin
    $display("[TB] dm_bridge bench start");
    test_reset();
    test_read_fast();
    test_write_wait();
    test_conflict();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
